frame_blitter: RTL

Parametrised double-buffer frame drawer: once per display frame it tiles a background sprite across the off-screen frame buffer, then overlays a positioned player sprite with clipping and optional transparency. It sits between the sprite ROM and the two VRAM write ports, replacing the fixed-size draw logic in the top level. It signals which buffer is being drawn so the display path reads the other.

---
 rtl/blit_pkg.sv | 15 +
 rtl/blit_scan.sv | 55 +++++
 rtl/frame_blitter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/blit_pkg.sv
// Shared types and constants for the frame blitter: draw-phase states,
// sprite-ROM-to-write pipeline depth and drain length.
package blit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BG,
        SPRITE,
        FLUSH
    } blit_state_e;

    localparam int unsigned PIPE_DEPTH = 2;
    localparam int unsigned FLUSH_LEN  = 2;

endpackage

// File: rtl/blit_scan.sv
// Raster counter: x runs 0..x_last then wraps and bumps y; the limits are
// inputs so the same counter serves the full-screen and the sprite pass.
module blit_scan
    import blit_pkg::*;
#(
    parameter int unsigned XW = 9,
    parameter int unsigned YW = 8
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          start_i,
    input  logic          step_i,
    input  logic [XW-1:0] x_last_i,
    input  logic [YW-1:0] y_last_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          row_end_o,
    output logic          last_o
);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    assign row_end_o = (x_q == x_last_i);
    assign last_o    = row_end_o && (y_q == y_last_i);
    assign x_o       = x_q;
    assign y_o       = y_q;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (start_i) begin
            x_d = '0;
            y_d = '0;
        end else if (step_i) begin
            if (row_end_o) begin
                x_d = '0;
                y_d = (y_q == y_last_i) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/frame_blitter.sv
// Double-buffer frame drawer: tiles a background sprite, then overlays a
// clipped player sprite. Define TRANSPARENCY_EN to skip TRANSPARENT_IDX pixels.
module frame_blitter
    import blit_pkg::*;
#(
    parameter int unsigned SCREEN_W        = 320,
    parameter int unsigned SCREEN_H        = 180,
    parameter int unsigned SPRITE_SIZE     = 32,
    parameter int unsigned SPRITE_COUNT    = 8,
    parameter int unsigned COLR_BITS       = 8,
    parameter int unsigned TRANSPARENT_IDX = 0
) (
    input  logic                                                   i_clk,
    input  logic                                                   i_rst_n,
    input  logic                                                   i_frame_start,
    input  logic [$clog2(SPRITE_COUNT)-1:0]                        i_bg_index,
    input  logic [$clog2(SPRITE_COUNT)-1:0]                        i_pl_index,
    input  logic [$clog2(SCREEN_W)-1:0]                            i_pl_x,
    input  logic [$clog2(SCREEN_H)-1:0]                            i_pl_y,
    output logic [$clog2(SPRITE_SIZE*SPRITE_SIZE*SPRITE_COUNT)-1:0] o_sp_addr,
    input  logic [COLR_BITS-1:0]                                   i_sp_data,
    output logic                                                   o_fb_we,
    output logic [$clog2(SCREEN_W*SCREEN_H)-1:0]                   o_fb_addr,
    output logic [COLR_BITS-1:0]                                   o_fb_data,
    output logic                                                   o_buf_sel,
    output logic                                                   o_busy,
    output logic                                                   o_overrun
);

    localparam int unsigned XW   = $clog2(SCREEN_W);
    localparam int unsigned YW   = $clog2(SCREEN_H);
    localparam int unsigned SW   = $clog2(SPRITE_SIZE);
    localparam int unsigned IW   = $clog2(SPRITE_COUNT);
    localparam int unsigned SAW  = $clog2(SPRITE_SIZE*SPRITE_SIZE*SPRITE_COUNT);
    localparam int unsigned FBW  = $clog2(SCREEN_W*SCREEN_H);
    localparam int unsigned LAST = PIPE_DEPTH - 1;

`ifdef TRANSPARENCY_EN
    localparam bit TRANSP_EN = 1'b1;
`else
    localparam bit TRANSP_EN = 1'b0;
`endif

    blit_state_e state_q, state_d;

    logic           buf_sel_q, overrun_q;
    logic [IW-1:0]  bg_idx_q, pl_idx_q;
    logic [XW-1:0]  pl_x_q;
    logic [YW-1:0]  pl_y_q;
    logic [FBW-1:0] bg_cnt_q, bg_cnt_d;
    logic [FBW-1:0] row_base_q, row_base_d;
    logic [1:0]     flush_cnt_q;

    logic           accept;
    logic           scan_start, scan_step, scan_row_end, scan_last;
    logic [XW-1:0]  scan_x, x_last;
    logic [YW-1:0]  scan_y, y_last;
    logic [XW:0]    px_w;
    logic [YW:0]    py_w;
    logic           clip;
    logic           scan_valid, scan_spr;
    logic [SAW-1:0] scan_sp_addr;
    logic [FBW-1:0] scan_fb_addr;
    logic           transp_hit;

    logic [SAW-1:0]       sp_addr_q;
    logic                 pv_q [PIPE_DEPTH];
    logic                 ps_q [PIPE_DEPTH];
    logic [FBW-1:0]       pa_q [PIPE_DEPTH];
    logic                 fb_we_q;
    logic [FBW-1:0]       fb_addr_q;
    logic [COLR_BITS-1:0] fb_data_q;

    assign accept = (state_q == IDLE) && i_frame_start;

    blit_scan #(
        .XW(XW),
        .YW(YW)
    ) u_scan (
        .clk_i    (i_clk),
        .rst_n_i  (i_rst_n),
        .start_i  (scan_start),
        .step_i   (scan_step),
        .x_last_i (x_last),
        .y_last_i (y_last),
        .x_o      (scan_x),
        .y_o      (scan_y),
        .row_end_o(scan_row_end),
        .last_o   (scan_last)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_frame_start) state_d = BG;
            BG:      if (scan_last) state_d = SPRITE;
            SPRITE:  if (scan_last) state_d = FLUSH;
            FLUSH:   if (flush_cnt_q == 2'(FLUSH_LEN - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One bit of headroom keeps the clip comparisons from wrapping at the screen edge.
    always_comb begin
        scan_start   = accept || ((state_q == BG) && scan_last);
        scan_step    = (state_q == BG) || (state_q == SPRITE);
        x_last       = (state_q == SPRITE) ? XW'(SPRITE_SIZE - 1) : XW'(SCREEN_W - 1);
        y_last       = (state_q == SPRITE) ? YW'(SPRITE_SIZE - 1) : YW'(SCREEN_H - 1);
        px_w         = {1'b0, pl_x_q} + (XW+1)'(scan_x);
        py_w         = {1'b0, pl_y_q} + (YW+1)'(scan_y);
        clip         = (px_w >= (XW+1)'(SCREEN_W)) || (py_w >= (YW+1)'(SCREEN_H));
        scan_valid   = 1'b0;
        scan_spr     = 1'b0;
        scan_sp_addr = '0;
        scan_fb_addr = '0;
        case (state_q)
            BG: begin
                scan_valid   = 1'b1;
                scan_sp_addr = SAW'({bg_idx_q, scan_y[SW-1:0], scan_x[SW-1:0]});
                scan_fb_addr = bg_cnt_q;
            end
            SPRITE: begin
                scan_valid   = !clip;
                scan_spr     = 1'b1;
                scan_sp_addr = SAW'({pl_idx_q, scan_y[SW-1:0], scan_x[SW-1:0]});
                scan_fb_addr = row_base_q + FBW'(scan_x);
            end
            default: ;
        endcase
    end

    always_comb begin
        bg_cnt_d   = bg_cnt_q;
        row_base_d = row_base_q;
        if (accept) begin
            bg_cnt_d   = '0;
            row_base_d = FBW'(i_pl_y) * FBW'(SCREEN_W) + FBW'(i_pl_x);
        end else begin
            if (state_q == BG) bg_cnt_d = bg_cnt_q + 1'b1;
            if ((state_q == SPRITE) && scan_row_end) row_base_d = row_base_q + FBW'(SCREEN_W);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            buf_sel_q   <= 1'b0;
            overrun_q   <= 1'b0;
            bg_idx_q    <= '0;
            pl_idx_q    <= '0;
            pl_x_q      <= '0;
            pl_y_q      <= '0;
            bg_cnt_q    <= '0;
            row_base_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            overrun_q   <= i_frame_start && (state_q != IDLE);
            bg_cnt_q    <= bg_cnt_d;
            row_base_q  <= row_base_d;
            flush_cnt_q <= (state_q == FLUSH) ? flush_cnt_q + 1'b1 : '0;
            if (accept) begin
                buf_sel_q <= !buf_sel_q;
                bg_idx_q  <= i_bg_index;
                pl_idx_q  <= i_pl_index;
                pl_x_q    <= i_pl_x;
                pl_y_q    <= i_pl_y;
            end
        end
    end

    assign transp_hit = (i_sp_data == COLR_BITS'(TRANSPARENT_IDX));

    // Write metadata rides alongside the ROM access so it lines up with i_sp_data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sp_addr_q <= '0;
            for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
                pv_q[i] <= 1'b0;
                ps_q[i] <= 1'b0;
                pa_q[i] <= '0;
            end
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
        end else begin
            sp_addr_q <= scan_sp_addr;
            pv_q[0]   <= scan_valid;
            ps_q[0]   <= scan_spr;
            pa_q[0]   <= scan_fb_addr;
            for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
                pv_q[i] <= pv_q[i-1];
                ps_q[i] <= ps_q[i-1];
                pa_q[i] <= pa_q[i-1];
            end
            fb_we_q <= pv_q[LAST] && !(TRANSP_EN && ps_q[LAST] && transp_hit);
            if (pv_q[LAST]) begin
                fb_addr_q <= pa_q[LAST];
                fb_data_q <= i_sp_data;
            end
        end
    end

    assign o_sp_addr = sp_addr_q;
    assign o_fb_we   = fb_we_q;
    assign o_fb_addr = fb_addr_q;
    assign o_fb_data = fb_data_q;
    assign o_buf_sel = buf_sel_q;
    assign o_busy    = (state_q != IDLE);
    assign o_overrun = overrun_q;

endmodule
